// File: rtl/core_mem_port.sv
// ---------------------------------------------------------------------------
// core_mem_port
//
// Per-core initiator for the shared main-memory arbiter. Accepts one command
// at a time from the core (READ, WRITE, LOCK, UNLOCK). It runs either the
// arbiter request/grant/access handshake or the mutex lock/unlock handshake,
// and then returns a single-cycle response pulse.
//
// Every output comes from a register, so there is no combinational path from
// any input to any output. The registered outputs are loaded from the decoded
// next state. Each output is therefore aligned with the state it describes.
//
// Parameters
//   READ_LAT   : cycles mem_read is held after grant (1..4); main_mem_dat is
//                captured on the last of them
//   WAIT_LIMIT : wait cycles in REQ_*/LOCK/UNLOCK after which starve sets
//                (2..255)
//
// Ports
//   clk, reset          : clock; synchronous active-high reset
//   cmd_valid/op/adr/dat: core command (op 0=READ 1=WRITE 2=LOCK 3=UNLOCK)
//   cmd_ready           : high only in IDLE
//   rsp_valid, rsp_dat  : one-cycle completion pulse and read data
//   starve              : sticky, set when a wait reaches WAIT_LIMIT
//   mem_*_request       : arbitration requests
//   mem_read, mem_write : access strobes
//   mem_*_adr, mem_write_dat : latched address / write data
//   main_mem_dat        : shared read data bus
//   mem_ac              : this core's grant bit
//   lock_adr            : latched mutex index (cmd_adr[9:0])
//   lock_en, unlock_en  : mutex requests
//   lock_ac             : this core's lock/unlock acknowledge
// ---------------------------------------------------------------------------
module core_mem_port #(
  parameter int READ_LAT   = 1,
  parameter int WAIT_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_adr,
  input  logic [15:0] cmd_dat,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_dat,
  output logic        starve,
  output logic        mem_read_request,
  output logic        mem_write_request,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_read_adr,
  output logic [15:0] mem_write_adr,
  output logic [15:0] mem_write_dat,
  input  logic [15:0] main_mem_dat,
  input  logic        mem_ac,
  output logic [9:0]  lock_adr,
  output logic        lock_en,
  output logic        unlock_en,
  input  logic        lock_ac
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_RD = 3'd1,
    ST_REQ_WR = 3'd2,
    ST_ACC_RD = 3'd3,
    ST_ACC_WR = 3'd4,
    ST_LOCK   = 3'd5,
    ST_UNLOCK = 3'd6,
    ST_RESP   = 3'd7
  } state_t;

  // Final value of the read-access counter. The counter starts at 0 on
  // entry to ACC_RD.
  localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_LIMIT);

  // The wait counter saturates so a very long wait cannot wrap.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = v;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_lat_cnt;
  logic [2:0]  w_lat_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_nxt;
  logic        w_accept;
  logic        w_wait_clr;
  logic        w_wait_inc;
  logic        w_lat_clr;
  logic        w_lat_inc;
  logic        w_capture;
  logic        w_rsp_zero;

  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_dat;
  logic        r_starve;
  logic        r_mem_read_request;
  logic        r_mem_write_request;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [15:0] r_mem_read_adr;
  logic [15:0] r_mem_write_adr;
  logic [15:0] r_mem_write_dat;
  logic [9:0]  r_lock_adr;
  logic        r_lock_en;
  logic        r_unlock_en;

  // Next-state logic and per-cycle control strobes for the counters and the data path
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_wait_clr  = 1'b0;
    w_wait_inc  = 1'b0;
    w_lat_clr   = 1'b0;
    w_lat_inc   = 1'b0;
    w_capture   = 1'b0;
    w_rsp_zero  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          // Every command enters a wait state, so the wait counter is
          // cleared at accept.
          w_accept   = 1'b1;
          w_wait_clr = 1'b1;
          case (cmd_op)
            2'd0:    w_state_nxt = ST_REQ_RD;
            2'd1:    w_state_nxt = ST_REQ_WR;
            2'd2:    w_state_nxt = ST_LOCK;
            default: w_state_nxt = ST_UNLOCK;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ_RD: begin
        if (mem_ac) begin
          w_state_nxt = ST_ACC_RD;
          w_lat_clr   = 1'b1;
        end else begin
          w_wait_inc  = 1'b1;
        end
      end
      ST_REQ_WR: begin
        if (mem_ac) begin
          w_state_nxt = ST_ACC_WR;
        end else begin
          w_wait_inc  = 1'b1;
        end
      end
      ST_ACC_RD: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_state_nxt = ST_RESP;
          w_capture   = 1'b1;
        end else begin
          w_lat_inc   = 1'b1;
        end
      end
      ST_ACC_WR: begin
        w_state_nxt = ST_RESP;
        w_rsp_zero  = 1'b1;
      end
      ST_LOCK, ST_UNLOCK: begin
        if (lock_ac) begin
          w_state_nxt = ST_RESP;
          w_rsp_zero  = 1'b1;
        end else begin
          w_wait_inc  = 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the read-latency counter and the wait counter
  always_comb begin
    w_lat_nxt  = r_lat_cnt;
    w_wait_nxt = r_wait_cnt;
    if (w_lat_clr) begin
      w_lat_nxt = 3'd0;
    end else if (w_lat_inc) begin
      w_lat_nxt = r_lat_cnt + 3'd1;
    end else begin
      w_lat_nxt = r_lat_cnt;
    end
    if (w_wait_clr) begin
      w_wait_nxt = 8'd0;
    end else if (w_wait_inc) begin
      w_wait_nxt = sat_inc8(r_wait_cnt);
    end else begin
      w_wait_nxt = r_wait_cnt;
    end
  end

  // State register and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_lat_cnt  <= 3'd0;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_lat_cnt  <= w_lat_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Handshake outputs, decoded from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_ready         <= 1'b1;
      r_rsp_valid         <= 1'b0;
      r_mem_read_request  <= 1'b0;
      r_mem_write_request <= 1'b0;
      r_mem_read          <= 1'b0;
      r_mem_write         <= 1'b0;
      r_lock_en           <= 1'b0;
      r_unlock_en         <= 1'b0;
    end else begin
      r_cmd_ready         <= (w_state_nxt == ST_IDLE);
      r_rsp_valid         <= (w_state_nxt == ST_RESP);
      r_mem_read_request  <= (w_state_nxt == ST_REQ_RD);
      r_mem_write_request <= (w_state_nxt == ST_REQ_WR);
      r_mem_read          <= (w_state_nxt == ST_ACC_RD);
      r_mem_write         <= (w_state_nxt == ST_ACC_WR);
      r_lock_en           <= (w_state_nxt == ST_LOCK);
      r_unlock_en         <= (w_state_nxt == ST_UNLOCK);
    end
  end

  // Sticky starvation flag: set on the edge at which the wait count reaches the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= 1'b0;
    end else if (w_wait_inc && (w_wait_nxt == WAIT_LIM)) begin
      r_starve <= 1'b1;
    end else begin
      r_starve <= r_starve;
    end
  end

  // Command latches: updated on the accept edge and held until the next accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_read_adr  <= 16'd0;
      r_mem_write_adr <= 16'd0;
      r_mem_write_dat <= 16'd0;
      r_lock_adr      <= 10'd0;
    end else if (w_accept) begin
      r_mem_read_adr  <= cmd_adr;
      r_mem_write_adr <= cmd_adr;
      r_mem_write_dat <= cmd_dat;
      r_lock_adr      <= cmd_adr[9:0];
    end else begin
      r_mem_read_adr  <= r_mem_read_adr;
      r_mem_write_adr <= r_mem_write_adr;
      r_mem_write_dat <= r_mem_write_dat;
      r_lock_adr      <= r_lock_adr;
    end
  end

  // Response data: read data is captured when the last access cycle ends;
  // other ops write 0 when they enter RESP; otherwise the value holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_dat <= 16'd0;
    end else if (w_capture) begin
      r_rsp_dat <= main_mem_dat;
    end else if (w_rsp_zero) begin
      r_rsp_dat <= 16'd0;
    end else begin
      r_rsp_dat <= r_rsp_dat;
    end
  end

  assign cmd_ready         = r_cmd_ready;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_dat           = r_rsp_dat;
  assign starve            = r_starve;
  assign mem_read_request  = r_mem_read_request;
  assign mem_write_request = r_mem_write_request;
  assign mem_read          = r_mem_read;
  assign mem_write         = r_mem_write;
  assign mem_read_adr      = r_mem_read_adr;
  assign mem_write_adr     = r_mem_write_adr;
  assign mem_write_dat     = r_mem_write_dat;
  assign lock_adr          = r_lock_adr;
  assign lock_en           = r_lock_en;
  assign unlock_en         = r_unlock_en;

endmodule

// File: tb/tb_core_mem_port.sv
// ---------------------------------------------------------------------------
// tb_core_mem_port
//
// Self-checking bench for core_mem_port. The expected behaviour of each
// command is a timeline. With a grant or acknowledge delay d and read
// latency L, the timeline is:
//   READ : request cycles 1..d+1, mem_read cycles d+2..d+1+L, rsp at d+2+L
//   WRITE: request cycles 1..d+1, mem_write cycle d+2,         rsp at d+3
//   LOCK/UNLOCK: enable cycles 1..d+1,                         rsp at d+2
// Cycle 1 is the cycle that follows the accept edge. Outputs are sampled on
// the negative edge, and inputs are driven on it too.
// ---------------------------------------------------------------------------
module tb_core_mem_port;

  localparam int RL = 3;
  localparam int WL = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_adr;
  logic [15:0] cmd_dat;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [15:0] rsp_dat;
  logic        starve;
  logic        mem_read_request;
  logic        mem_write_request;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_read_adr;
  logic [15:0] mem_write_adr;
  logic [15:0] mem_write_dat;
  logic [15:0] main_mem_dat;
  logic        mem_ac;
  logic [9:0]  lock_adr;
  logic        lock_en;
  logic        unlock_en;
  logic        lock_ac;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic        m_starve;
  logic [15:0] m_rsp_dat;
  logic [15:0] m_adr;
  logic [15:0] m_dat;

  core_mem_port #(.READ_LAT(RL), .WAIT_LIMIT(WL)) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_op            (cmd_op),
    .cmd_adr           (cmd_adr),
    .cmd_dat           (cmd_dat),
    .cmd_ready         (cmd_ready),
    .rsp_valid         (rsp_valid),
    .rsp_dat           (rsp_dat),
    .starve            (starve),
    .mem_read_request  (mem_read_request),
    .mem_write_request (mem_write_request),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_read_adr      (mem_read_adr),
    .mem_write_adr     (mem_write_adr),
    .mem_write_dat     (mem_write_dat),
    .main_mem_dat      (main_mem_dat),
    .mem_ac            (mem_ac),
    .lock_adr          (lock_adr),
    .lock_en           (lock_en),
    .unlock_en         (unlock_en),
    .lock_ac           (lock_ac)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs_vec();
    return {cmd_ready, rsp_valid, mem_read_request, mem_write_request,
            mem_read, mem_write, lock_en, unlock_en};
  endfunction

  function automatic logic [57:0] obs_lat();
    return {mem_read_adr, mem_write_adr, mem_write_dat, lock_adr};
  endfunction

  task automatic model_clear();
    m_starve  = 1'b0;
    m_rsp_dat = 16'd0;
    m_adr     = 16'd0;
    m_dat     = 16'd0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    mem_ac    = 1'b0;
    lock_ac   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // Issue one command with delay d and check every cycle through the return to IDLE.
  task automatic run_op(input logic [1:0] op, input logic [15:0] adr,
                        input logic [15:0] dat, input int d,
                        input bit fix_rd, input logic [15:0] rd_val);
    int          t;
    logic [15:0] rd_cap;
    logic [7:0]  ev;
    logic [57:0] el;
    rd_cap = 16'd0;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_before_accept: got %b need 1", cmd_ready);
    end
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_adr      = adr;
    cmd_dat      = dat;
    mem_ac       = 1'($urandom_range(1, 0));
    lock_ac      = 1'($urandom_range(1, 0));
    main_mem_dat = 16'($urandom);
    m_adr        = adr;
    m_dat        = dat;
    if (op == 2'd0)      t = d + 2 + RL;
    else if (op == 2'd1) t = d + 3;
    else                 t = d + 2;
    for (int c = 1; c <= t + 1; c++) begin
      @(negedge clk);
      if (c == t) m_rsp_dat = (op == 2'd0) ? rd_cap : 16'd0;
      if (d >= WL && c >= WL + 1) m_starve = 1'b1;
      ev = {c == t + 1, c == t,
            op == 2'd0 && c <= d + 1, op == 2'd1 && c <= d + 1,
            op == 2'd0 && c >= d + 2 && c <= d + 1 + RL,
            op == 2'd1 && c == d + 2,
            op == 2'd2 && c <= d + 1, op == 2'd3 && c <= d + 1};
      el = {m_adr, m_adr, m_dat, m_adr[9:0]};
      n_cmp++;
      if (obs_vec() !== ev) begin
        n_err++;
        $display("FAIL strobes op%0d d%0d cyc%0d: got %b need %b", op, d, c, obs_vec(), ev);
      end
      n_cmp++;
      if (rsp_dat !== m_rsp_dat) begin
        n_err++;
        $display("FAIL rsp_dat op%0d cyc%0d: got %h need %h", op, c, rsp_dat, m_rsp_dat);
      end
      n_cmp++;
      if (starve !== m_starve) begin
        n_err++;
        $display("FAIL starve op%0d d%0d cyc%0d: got %b need %b", op, d, c, starve, m_starve);
      end
      n_cmp++;
      if (obs_lat() !== el) begin
        n_err++;
        $display("FAIL latched op%0d cyc%0d: got %h need %h", op, c, obs_lat(), el);
      end
      // Drive the next edge. Commands offered while busy must be ignored.
      if (c <= t) begin
        cmd_valid = 1'($urandom_range(1, 0));
        cmd_op    = 2'($urandom);
        cmd_adr   = 16'($urandom);
        cmd_dat   = 16'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      if (op <= 2'd1 && c <= d + 1) mem_ac = (c == d + 1);
      else                          mem_ac = 1'($urandom_range(1, 0));
      if (op >= 2'd2 && c <= d + 1) lock_ac = (c == d + 1);
      else                          lock_ac = 1'($urandom_range(1, 0));
      main_mem_dat = (fix_rd && c > d) ? rd_val : 16'($urandom);
      if (op == 2'd0 && c == d + 1 + RL) rd_cap = main_mem_dat;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs_vec() !== 8'b1000_0000) begin
      n_err++;
      $display("FAIL reset_strobes: got %b need 10000000", obs_vec());
    end
    n_cmp++;
    if ({rsp_dat, starve} !== 17'd0 || obs_lat() !== 58'd0) begin
      n_err++;
      $display("FAIL reset_data: rsp %h starve %b lat %h need zeros", rsp_dat, starve, obs_lat());
    end
  endtask

  task automatic test_single_read();
    run_op(2'd0, 16'h0123, 16'($urandom), 0, 1'b1, 16'hBEEF);
    n_cmp++;
    if (rsp_dat !== 16'hBEEF || mem_read_adr !== 16'h0123) begin
      n_err++;
      $display("FAIL single_read: rsp %h adr %h need beef 0123", rsp_dat, mem_read_adr);
    end
  endtask

  task automatic test_delayed_write();
    run_op(2'd1, 16'h0040, 16'h5A5A, 5, 1'b0, 16'd0);
    n_cmp++;
    if (starve !== 1'b0 || rsp_dat !== 16'd0) begin
      n_err++;
      $display("FAIL delayed_write: starve %b rsp %h need 0 0000", starve, rsp_dat);
    end
  endtask

  task automatic test_lock_unlock();
    run_op(2'd2, 16'h03FF, 16'($urandom), 2, 1'b0, 16'd0);
    n_cmp++;
    if (lock_adr !== 10'h3FF) begin
      n_err++;
      $display("FAIL lock_adr: got %h need 3ff", lock_adr);
    end
    run_op(2'd3, 16'h03FF, 16'($urandom), 3, 1'b0, 16'd0);
  endtask

  task automatic test_starvation();
    do_reset();
    run_op(2'd0, 16'($urandom), 16'($urandom), 10, 1'b0, 16'd0);
    run_op(2'd1, 16'($urandom), 16'($urandom), 0, 1'b0, 16'd0);
    n_cmp++;
    if (starve !== 1'b1) begin
      n_err++;
      $display("FAIL starve_sticky: got %b need 1", starve);
    end
    do_reset();
    n_cmp++;
    if (starve !== 1'b0) begin
      n_err++;
      $display("FAIL starve_reset: got %b need 0", starve);
    end
  endtask

  task automatic test_reset_mid_access();
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_adr   = 16'($urandom);
    cmd_dat   = 16'($urandom);
    mem_ac    = 1'b0;
    @(negedge clk);             // cycle 1: REQ_RD
    cmd_valid = 1'b0;
    mem_ac    = 1'b1;
    @(negedge clk);             // cycle 2: first ACC_RD cycle
    mem_ac    = 1'b0;
    n_cmp++;
    if (mem_read !== 1'b1) begin
      n_err++;
      $display("FAIL mid_access_setup: mem_read %b need 1", mem_read);
    end
    @(negedge clk);             // cycle 3: still ACC_RD
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (obs_vec() !== 8'b1000_0000 || rsp_dat !== 16'd0 || obs_lat() !== 58'd0) begin
        n_err++;
        $display("FAIL mid_reset k%0d: strobes %b rsp %h lat %h need 10000000 0 0",
                 k, obs_vec(), rsp_dat, obs_lat());
      end
      mem_ac  = 1'($urandom_range(1, 0));
      lock_ac = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
  endtask

  task automatic test_robust();
    run_op(2'd0, 16'($urandom), 16'($urandom), 1, 1'b0, 16'd0);
    for (int k = 0; k < 6; k++) begin
      mem_ac    = k[0];
      lock_ac   = ~k[0];
      cmd_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== 8'b1000_0000 || rsp_dat !== m_rsp_dat ||
          obs_lat() !== {m_adr, m_adr, m_dat, m_adr[9:0]}) begin
        n_err++;
        $display("FAIL idle_spurious k%0d: strobes %b rsp %h need 10000000 %h",
                 k, obs_vec(), rsp_dat, m_rsp_dat);
      end
    end
    run_op(2'd1, 16'($urandom), 16'($urandom), 3, 1'b0, 16'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(8, 0)), 1'b0, 16'd0);
    end
  endtask

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_op       = 2'd0;
    cmd_adr      = 16'd0;
    cmd_dat      = 16'd0;
    main_mem_dat = 16'd0;
    mem_ac       = 1'b0;
    lock_ac      = 1'b0;
    model_clear();
    test_reset();
    test_single_read();
    test_delayed_write();
    test_lock_unlock();
    test_starvation();
    test_reset_mid_access();
    test_robust();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
